// File: rtl/alu_writeback_regfile.sv
// Writeback end of the ALU result path: one-cycle writeback latch, register file
// commit, and two bypassed combinational operand read ports.
module alu_writeback_regfile #(
    parameter int OPERAND_SIZE     = 32,
    parameter int REG_ADDRESS_SIZE = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid_in,
    input  logic [OPERAND_SIZE-1:0]       wb_result_in,
    input  logic [REG_ADDRESS_SIZE:0]     wb_static_in,
    input  logic                          stall,
    input  logic [REG_ADDRESS_SIZE-1:0]   rd_addr1,
    input  logic [REG_ADDRESS_SIZE-1:0]   rd_addr2,
    output logic [OPERAND_SIZE-1:0]       rd_data1,
    output logic [OPERAND_SIZE-1:0]       rd_data2,
    output logic                          commit_valid,
    output logic [REG_ADDRESS_SIZE-1:0]   commit_addr,
    output logic [OPERAND_SIZE-1:0]       commit_data
);

    localparam int NUM_REGS = 1 << REG_ADDRESS_SIZE;

    logic [OPERAND_SIZE-1:0]     regs_q [NUM_REGS];
    logic                        wbl_valid_q;
    logic [REG_ADDRESS_SIZE-1:0] wbl_addr_q;
    logic [OPERAND_SIZE-1:0]     wbl_data_q;
    logic                        commit_valid_q;
    logic [REG_ADDRESS_SIZE-1:0] commit_addr_q;
    logic [OPERAND_SIZE-1:0]     commit_data_q;

    logic                        in_we;
    logic [REG_ADDRESS_SIZE-1:0] in_addr;
    logic                        in_hit;
    logic                        in_accept;

    assign in_we     = wb_static_in[REG_ADDRESS_SIZE];
    assign in_addr   = wb_static_in[REG_ADDRESS_SIZE-1:0];
    // in_hit ignores stall so a held input is still forwarded while frozen
    assign in_hit    = wb_valid_in && in_we && (in_addr != '0);
    assign in_accept = in_hit && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wbl_valid_q    <= 1'b0;
            wbl_addr_q     <= '0;
            wbl_data_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
            commit_data_q  <= '0;
        end else if (stall) begin
            commit_valid_q <= 1'b0;
        end else begin
            wbl_valid_q <= in_accept;
            wbl_addr_q  <= in_addr;
            wbl_data_q  <= wb_result_in;
            if (wbl_valid_q) begin
                regs_q[wbl_addr_q] <= wbl_data_q;
                commit_valid_q     <= 1'b1;
                commit_addr_q      <= wbl_addr_q;
                commit_data_q      <= wbl_data_q;
            end else begin
                commit_valid_q <= 1'b0;
            end
        end
    end

    // Newest value wins: live input, then latch, then array
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (in_hit && (in_addr == rd_addr1)) begin
            rd_data1 = wb_result_in;
        end else if (wbl_valid_q && (wbl_addr_q == rd_addr1)) begin
            rd_data1 = wbl_data_q;
        end
    end

    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end else if (in_hit && (in_addr == rd_addr2)) begin
            rd_data2 = wb_result_in;
        end else if (wbl_valid_q && (wbl_addr_q == rd_addr2)) begin
            rd_data2 = wbl_data_q;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_addr  = commit_addr_q;
    assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Directed bench for alu_writeback_regfile: hand-computed expectations for
// bypass, commit timing, stall and reset behaviour.
module tb_alu_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid_in;
    logic [31:0] wb_result_in;
    logic [5:0]  wb_static_in;
    logic        stall;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        commit_valid;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;

    int n_checks = 0;
    int n_pass   = 0;

    alu_writeback_regfile #(.OPERAND_SIZE(32), .REG_ADDRESS_SIZE(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid_in  (wb_valid_in),
        .wb_result_in (wb_result_in),
        .wb_static_in (wb_static_in),
        .stall        (stall),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs change just after a rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] st, input logic [31:0] res);
        wb_valid_in  = v;
        wb_static_in = st;
        wb_result_in = res;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 6'd0, 32'd0);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        drive(1'b0, 6'd0, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Reset then read
        rd_addr1 = 5'd0; rd_addr2 = 5'd7;
        @(negedge clk);
        chk("rst_r0", rd_data1, 32'd0);
        chk("rst_r7", rd_data2, 32'd0);
        chk("rst_cv", {31'd0, commit_valid}, 32'd0);
        chk("rst_ca", {27'd0, commit_addr}, 32'd0);
        chk("rst_cd", commit_data, 32'd0);
        rd_addr1 = 5'd31;
        #1;
        chk("rst_r31", rd_data1, 32'd0);
        next_cycle();

        // Simple write to r5
        rd_addr1 = 5'd5;
        drive(1'b1, 6'b1_00101, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_c0_rd", rd_data1, 32'hDEADBEEF);
        chk("sw_c0_cv", {31'd0, commit_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 6'd0, 32'd0);
        @(negedge clk);
        chk("sw_c1_rd", rd_data1, 32'hDEADBEEF);
        chk("sw_c1_cv", {31'd0, commit_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("sw_c2_rd", rd_data1, 32'hDEADBEEF);
        chk("sw_c2_cv", {31'd0, commit_valid}, 32'd1);
        chk("sw_c2_ca", {27'd0, commit_addr}, 32'd5);
        chk("sw_c2_cd", commit_data, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        chk("sw_c3_cv", {31'd0, commit_valid}, 32'd0);
        chk("sw_c3_ca_hold", {27'd0, commit_addr}, 32'd5);
        chk("sw_c3_cd_hold", commit_data, 32'hDEADBEEF);
        chk("sw_c3_rd", rd_data1, 32'hDEADBEEF);
        idle(2);

        // Write to r0 and write-enable 0 are discarded
        rd_addr1 = 5'd0; rd_addr2 = 5'd3;
        drive(1'b1, 6'b1_00000, 32'h1234);
        @(negedge clk);
        chk("r0_rd", rd_data1, 32'd0);
        next_cycle();
        drive(1'b1, 6'b0_00011, 32'h55);
        @(negedge clk);
        chk("we0_rd_c1", rd_data2, 32'd0);
        chk("we0_cv_c1", {31'd0, commit_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 6'd0, 32'd0);
        @(negedge clk);
        chk("we0_cv_c2", {31'd0, commit_valid}, 32'd0);
        chk("we0_rd_c2", rd_data2, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("we0_cv_c3", {31'd0, commit_valid}, 32'd0);
        chk("we0_rd_c3", rd_data2, 32'd0);
        chk("we0_r0_c3", rd_data1, 32'd0);
        idle(2);

        // Same-address back-to-back on r9, read on both ports
        rd_addr1 = 5'd9; rd_addr2 = 5'd9;
        drive(1'b1, 6'b1_01001, 32'h1);
        @(negedge clk);
        chk("b2b_c0_rd1", rd_data1, 32'h1);
        next_cycle();
        drive(1'b1, 6'b1_01001, 32'h2);
        @(negedge clk);
        chk("b2b_c1_rd1", rd_data1, 32'h2);
        chk("b2b_c1_rd2", rd_data2, 32'h2);
        next_cycle();
        drive(1'b0, 6'd0, 32'd0);
        @(negedge clk);
        chk("b2b_c2_rd1", rd_data1, 32'h2);
        chk("b2b_c2_cv", {31'd0, commit_valid}, 32'd1);
        chk("b2b_c2_cd", commit_data, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("b2b_c3_rd1", rd_data1, 32'h2);
        chk("b2b_c3_cv", {31'd0, commit_valid}, 32'd1);
        chk("b2b_c3_cd", commit_data, 32'h2);
        next_cycle();
        @(negedge clk);
        chk("b2b_c4_rd2", rd_data2, 32'h2);
        chk("b2b_c4_cv", {31'd0, commit_valid}, 32'd0);
        idle(2);

        // Stall: r4 held in latch; r20 presented during stall is only forwarded
        rd_addr1 = 5'd4; rd_addr2 = 5'd20;
        drive(1'b1, 6'b1_00100, 32'hA5);
        @(negedge clk);
        chk("st_c0_rd", rd_data1, 32'hA5);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            stall = 1'b1;
            if (c == 3) drive(1'b1, 6'b1_10100, 32'h77);
            else drive(1'b0, 6'd0, 32'd0);
            @(negedge clk);
            chk($sformatf("st_c%0d_rd", c), rd_data1, 32'hA5);
            chk($sformatf("st_c%0d_cv", c), {31'd0, commit_valid}, 32'd0);
        end
        chk("st_c3_fwd", rd_data2, 32'h77);
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        chk("st_c4_cv", {31'd0, commit_valid}, 32'd0);
        chk("st_c4_rd", rd_data1, 32'hA5);
        chk("st_c4_fwd", rd_data2, 32'h77);
        next_cycle();
        drive(1'b0, 6'd0, 32'd0);
        @(negedge clk);
        chk("st_c5_cv", {31'd0, commit_valid}, 32'd1);
        chk("st_c5_ca", {27'd0, commit_addr}, 32'd4);
        chk("st_c5_cd", commit_data, 32'hA5);
        chk("st_c5_rd2", rd_data2, 32'h77);
        next_cycle();
        @(negedge clk);
        chk("st_c6_cv", {31'd0, commit_valid}, 32'd1);
        chk("st_c6_ca", {27'd0, commit_addr}, 32'd20);
        chk("st_c6_cd", commit_data, 32'h77);
        idle(2);

        // Reset mid-flight drops the latched r12 result and clears the array
        rd_addr1 = 5'd12; rd_addr2 = 5'd5;
        drive(1'b1, 6'b1_01100, 32'hFF);
        @(negedge clk);
        chk("rmf_c0_rd", rd_data1, 32'hFF);
        next_cycle();
        drive(1'b0, 6'd0, 32'd0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rmf_c2_rd", rd_data1, 32'd0);
        chk("rmf_c2_cv", {31'd0, commit_valid}, 32'd0);
        chk("rmf_c2_r5", rd_data2, 32'd0);
        chk("rmf_c2_cd", commit_data, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rmf_c3_rd", rd_data1, 32'd0);
        chk("rmf_c3_cv", {31'd0, commit_valid}, 32'd0);
        rd_addr2 = 5'd4;
        #1;
        chk("rmf_c3_r4", rd_data2, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback_regfile.md
# alu_writeback_regfile

Consumer end of the ALU result interface: captures `ALU_result` and its static field (write-enable bit plus destination register address), holds it for one cycle in a writeback latch, then commits it into a 2^REG_ADDRESS_SIZE-entry register file. The block also supplies the two ALU source operands from that register file, with bypass from in-flight results. This closes the loop between the ALU and the datapath that feeds it.

## Interface
- OPERAND_SIZE, 32, width of data words and register entries
- REG_ADDRESS_SIZE, 5, register address width; the array holds 2^REG_ADDRESS_SIZE entries
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wb_valid_in  in  1  result on `wb_result_in` is valid this cycle
- wb_result_in  in  OPERAND_SIZE  ALU result
- wb_static_in  in  REG_ADDRESS_SIZE+1  bit [REG_ADDRESS_SIZE] = write enable; bits [REG_ADDRESS_SIZE-1:0] = destination address
- stall  in  1  freeze writeback latch and commit
- rd_addr1, rd_addr2  in  REG_ADDRESS_SIZE each  operand read addresses
- rd_data1, rd_data2  out  OPERAND_SIZE each  operand values (combinational)
- commit_valid  out  1  registered; an entry was written this edge
- commit_addr  out  REG_ADDRESS_SIZE  registered address of the last commit
- commit_data  out  OPERAND_SIZE  registered data of the last commit

## Operation
- Input acceptance: an input is accepted when `wb_valid_in` is 1, write enable is 1, destination is not 0, and `stall` is 0. Otherwise it is discarded and the latch loads as invalid, unless stalled.
- Writeback latch (wbl_valid, wbl_addr, wbl_data) is loaded every unstalled edge.
- Commit: on an unstalled edge with wbl_valid=1:
  - array[wbl_addr] <= wbl_data
  - commit_valid <= 1; commit_addr and commit_data take the latch contents.
  - Otherwise commit_valid <= 0, and commit_addr/commit_data hold their values.
- Stall=1: latch, array and commit_addr/commit_data hold; commit_valid <= 0. The latch contents stay visible to bypass.
- Register 0 always reads 0 and is never written.
- Read priority per port, evaluated combinationally:
  - address 0 -> 0
  - else accepted input matching the address (ignoring stall) -> `wb_result_in`
  - else wbl_valid with wbl_addr matching -> wbl_data
  - else array entry
- Both ports are independent and may use the same address.
- No arithmetic. All widths are pass-through; no truncation or extension.

## Timing
- Result presented in cycle N and accepted: visible on the read ports in cycle N via bypass, and in the latch during N+1. Written to the array and reported on commit_* after the edge ending N+1. Unstalled commit latency is 2 edges.
- Back-to-back writes to the same address: the newer value wins on the read ports in every cycle. The array ends with the newer value after its commit.
- Input stalled in cycle N: treated as not accepted for the latch. Upstream must hold it; the bypass still shows it while it is held.
- Reset, on the edge where `reset`=1:
  - all array entries <= 0
  - latch invalid, wbl_addr=0, wbl_data=0
  - commit_valid=0, commit_addr=0, commit_data=0
- Reset has priority over stall and input. A result in the latch at reset is dropped and never committed.
- rd_data1/rd_data2 after reset read 0 for every address until written.

## Test plan
- Reset then read: assert reset 1 cycle; read addresses 0, 7, 31 -> all 0; commit_valid=0.
- Simple write: cycle 0 valid, static=6'b1_00101, result=32'hDEADBEEF -> rd_data1 (addr 5) = DEADBEEF in cycles 0, 1 and 2; commit_valid=1, commit_addr=5, commit_data=DEADBEEF after edge 1 only.
- Write to r0 / write-enable 0: static=6'b1_00000 result 32'h1234, then static=6'b0_00011 result 32'h55 -> r0 and r3 read 0; no commit pulse.
- Same-address back-to-back: r9<=32'h1 cycle 0, r9<=32'h2 cycle 1 -> rd reads 1 in cycle 0, 2 from cycle 1 onward; two commit pulses, 1 then 2.
- Stall: r4<=32'hA5 in cycle 0, stall=1 cycles 1-3 -> r4 reads A5 throughout; commit_valid=0 during stall; commit pulse with A5 on the first unstalled edge.
- Reset mid-flight: r12<=32'hFF in cycle 0, reset in cycle 1 -> no commit; r12 reads 0 afterward.
